mmio_uart_tx: RTL

- Memory-mapped UART transmitter on the CPU data-memory port, downstream of the single-cycle core alongside the data memory.
- Stores to its address window push bytes into a TX FIFO, which is serialised as 8N1 frames on `tx`.
- Loads return status and divisor combinationally, so a single-cycle load completes in the same cycle.
- The top level muxes `read_data` using `sel`.

---
 rtl/mmio_uart_tx.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and CPU-visible status/divisor registers.
// Latency: a push into an empty, idle block pops on the next edge, and tx falls on that same edge.
// Backpressure: none toward the CPU; a push into a full FIFO is dropped and sets sticky overflow.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  output logic        sel,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        tx_idle_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_n;
  logic            overflow, overflow_n;
  logic [15:0]     bauddiv;
  logic [7:0]      shift, shift_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [15:0]     baud_cnt, baud_cnt_n;
  logic            tx_n, irq_n;
  logic            pop, push_req, push_ok, full, empty, busy, bit_end;
  logic            wr_hit;
  logic [1:0]      offset;
  logic            unused_bits;

  // Low address bits and the upper store-data half carry no meaning here.
  assign unused_bits = ^{address[1:0], write_data[31:16]};

  assign sel      = (address[31:4] == BASE_ADDR[31:4]);
  assign offset   = address[3:2];
  assign wr_hit   = write_enable && sel;
  assign push_req = wr_hit && (offset == 2'd0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  // A pop at the same edge frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req && (!full || pop);
  assign bit_end  = (baud_cnt == 16'd0);

  // Combinational register readback so a single-cycle load completes in place.
  always_comb begin
    read_data = 32'd0;
    if (sel) begin
      case (offset)
        2'd1:    read_data = {28'd0, overflow, busy, empty, full};
        2'd2:    read_data = {16'd0, bauddiv};
        default: read_data = 32'd0;
      endcase
    end
  end

  // Next-state for the transmit FSM, shifter, bit timing, FIFO count and flags.
  always_comb begin
    state_n    = state;
    shift_n    = shift;
    bit_cnt_n  = bit_cnt;
    baud_cnt_n = baud_cnt;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shift_n    = mem[rd_ptr];
          bit_cnt_n  = 3'd0;
          baud_cnt_n = bauddiv;
          state_n    = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_n = bauddiv;
          state_n    = DATA;
        end else begin
          baud_cnt_n = baud_cnt - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_n = bauddiv;
          shift_n    = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) state_n = STOP;
          else                 bit_cnt_n = bit_cnt + 3'd1;
        end else begin
          baud_cnt_n = baud_cnt - 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next frame when data is waiting.
          if (!empty) begin
            pop        = 1'b1;
            shift_n    = mem[rd_ptr];
            bit_cnt_n  = 3'd0;
            baud_cnt_n = bauddiv;
            state_n    = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt - 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    case ({push_ok, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase

    // Setting wins over a same-edge clear.
    overflow_n = overflow;
    if (push_req && full && !pop)
      overflow_n = 1'b1;
    else if (wr_hit && (offset == 2'd1) && write_data[3])
      overflow_n = 1'b0;

    tx_n  = (state_n == START) ? 1'b0 :
            (state_n == DATA)  ? shift_n[0] : 1'b1;
    irq_n = (count_n == '0) && (state_n == IDLE);
  end

  // State, pointers, flags and the registered line outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      bauddiv     <= DEFAULT_DIV;
      shift       <= 8'd0;
      bit_cnt     <= 3'd0;
      baud_cnt    <= 16'd0;
      tx          <= 1'b1;
      tx_idle_irq <= 1'b1;
    end else begin
      state       <= state_n;
      count       <= count_n;
      overflow    <= overflow_n;
      shift       <= shift_n;
      bit_cnt     <= bit_cnt_n;
      baud_cnt    <= baud_cnt_n;
      tx          <= tx_n;
      tx_idle_irq <= irq_n;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (wr_hit && (offset == 2'd2)) bauddiv <= write_data[15:0];
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= write_data[7:0];
  end

endmodule
